tagged_sample_fifo: RTL and testbench
=====================================

Name: tagged_sample_fifo

Overview:
- Downstream consumer of the 4-bit sample registers (`data`/`d2`) produced by the per-cycle update stage.
- Buffers each captured sample together with a 1-bit security tag (0 = L, 1 = H) in a small circular FIFO.
- Presents samples to an observer port through a valid/ready handshake.
- Any entry whose tag exceeds the observer's clearance is zeroed on output, so H data never reaches an L observer.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, ≥ 2.
- WIDTH, 4, sample width in bits.
- OBS_LEVEL, 0, observer clearance (0 = L, 1 = H); an entry is masked when its tag > OBS_LEVEL.

Ports:
- clk  input  1  clock, label {L}
- reset  input  1  asynchronous active-high reset, label {L}
- flush  input  1  synchronous clear of all entries, label {L}
- in_valid  input  1  producer has a sample, label {L}
- in_data  input  WIDTH  sample, label {Par in_tag}
- in_tag  input  1  security tag of in_data, label {L}
- in_ready  output  1  FIFO can accept, label {L}
- out_valid  output  1  head entry present, label {L}
- out_ready  input  1  observer accepts head, label {L}
- out_data  output  WIDTH  head sample or zero if masked, label {L}
- out_tag  output  1  head tag, label {L}
- out_masked  output  1  head entry suppressed for this observer, label {L}
- count  output  log2(DEPTH)+1  current occupancy, label {L}
- overflow  output  1  sticky: a push was attempted while full, label {L}

Behaviour:
- Clock and reset: one clock `clk`; `reset` is asynchronous, active-high.
- Reset values:
  - Read pointer, write pointer and count are 0.
  - overflow = 0; out_valid = 0; in_ready = 1.
  - out_data = 0, out_tag = 0, out_masked = 0.
  - Storage contents are don't-care.
- Flags: full = (count == DEPTH); empty = (count == 0). in_ready = !full; out_valid = !empty.
- Handshake events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both are evaluated at the rising edge.
- Push: writes {in_tag, in_data} at the write pointer, then advances the write pointer by 1 mod DEPTH.
- Pop: advances the read pointer by 1 mod DEPTH.
- Count update:
  - push & !pop: +1.
  - pop & !push: -1.
  - Both or neither: unchanged.
- Full FIFO: in_ready = 0 even if out_ready is high. There is no same-cycle push-through.
- Empty FIFO: no bypass. A sample pushed at edge N is visible on out_* after edge N, so latency is 1 cycle.
- Head outputs are combinational from storage at the read pointer:
  - out_tag = stored tag.
  - out_masked = out_valid & (stored tag > OBS_LEVEL).
  - out_data = 0 when out_masked or !out_valid; otherwise the stored sample.
- Masked entries still occupy a slot and still require a pop. The observer sees the tag and the mask, never the value.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count only.
- Overflow: set at any edge where in_valid & !in_ready. It stays set until reset; flush does not clear it.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Pointers and count go to 0 at the edge.
  - overflow is unaffected.
- Reset mid-operation: all state returns to the reset values immediately, without waiting for a clock edge. Outputs follow combinationally.

Test Plan:
- Fill then drain: reset, push samples 0x3, 0x5, 0x9, 0xC all with tag 0, out_ready = 0 → count = 4, in_ready = 0. Then out_ready = 1 → out_data reads 0x3, 0x5, 0x9, 0xC on consecutive cycles, count returns to 0, out_valid = 0.
- Masking: OBS_LEVEL = 0, push 0xA with tag 1 → out_valid = 1, out_masked = 1, out_data = 0x0, out_tag = 1. Pop → count = 0. Repeat with OBS_LEVEL = 1 → out_data = 0xA, out_masked = 0.
- Full plus simultaneous pop: with count = 4, drive in_valid = 1 and out_ready = 1 → pop only, count = 3, overflow = 1. The next cycle's push is accepted and count = 4.
- Wrap-around: push and pop simultaneously every cycle for 10 cycles with data 0..9 (count held at 1 after the first push) → output sequence 0..9 in order with no loss, and both pointers wrap twice.
- Flush vs. overflow: set overflow, then assert flush together with a push and a pop → count = 0, out_valid = 0, overflow still 1.
- Asynchronous reset: hold count = 2, assert reset between clock edges → count = 0, out_valid = 0 and overflow = 0 before the next edge; after release, the first push of 0x7 appears one cycle later.

Source files
------------

// File: rtl/tagged_sample_fifo.sv
// Circular FIFO of tagged 4-bit samples with a valid/ready observer port.
// Head entries tagged above the observer's clearance are presented with zeroed data.
module tagged_sample_fifo #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned OBS_LEVEL = 0,
  localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW       = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_tag,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_tag,
  output logic             out_masked,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam logic [CW-1:0] FullCount = CW'(DEPTH);
  localparam logic          ObsTag    = (OBS_LEVEL != 0);

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic             mem_tag  [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic full, empty, push, pop;
  logic head_tag;
  logic [WIDTH-1:0] head_data;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);

  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    // Sticky: flush deliberately leaves it alone.
    overflow_d = overflow_q | (in_valid & !in_ready);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; a flushed write is dropped so the slot is not touched.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_data[wr_ptr_q] <= in_data;
      mem_tag[wr_ptr_q]  <= in_tag;
    end
  end

  assign head_tag  = mem_tag[rd_ptr_q];
  assign head_data = mem_data[rd_ptr_q];

  always_comb begin
    out_tag    = 1'b0;
    out_masked = 1'b0;
    out_data   = '0;
    if (out_valid) begin
      out_tag    = head_tag;
      out_masked = (head_tag & !ObsTag);
      out_data   = out_masked ? '0 : head_data;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_tagged_sample_fifo.sv
// Randomized and directed bench for tagged_sample_fifo: queue-based reference model,
// one DUT per observer clearance, negedge monitor comparing against the model head.
module tb_tagged_sample_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             tag;
  } entry_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_tag;
  logic             out_ready;

  logic             in_ready_l, out_valid_l, out_tag_l, out_masked_l, overflow_l;
  logic [WIDTH-1:0] out_data_l;
  logic [2:0]       count_l;
  logic             in_ready_h, out_valid_h, out_tag_h, out_masked_h, overflow_h;
  logic [WIDTH-1:0] out_data_h;
  logic [2:0]       count_h;

  int total  = 0;
  int passed = 0;

  entry_t m_q[$];
  bit     m_ovf;

  always #5 clk = ~clk;

  tagged_sample_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .OBS_LEVEL(0)) dut_l (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_tag(in_tag), .in_ready(in_ready_l), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_data(out_data_l), .out_tag(out_tag_l), .out_masked(out_masked_l),
    .count(count_l), .overflow(overflow_l)
  );

  tagged_sample_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .OBS_LEVEL(1)) dut_h (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_tag(in_tag), .in_ready(in_ready_h), .out_valid(out_valid_h), .out_ready(out_ready),
    .out_data(out_data_h), .out_tag(out_tag_h), .out_masked(out_masked_h),
    .count(count_h), .overflow(overflow_h)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a bounded queue updated from the handshake rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      int  sz;
      bit  do_push, do_pop;
      sz = m_q.size();
      if (in_valid && sz == DEPTH) m_ovf = 1'b1;
      if (flush) begin
        m_q.delete();
      end else begin
        do_pop  = (sz > 0) && out_ready;
        do_push = in_valid && (sz < DEPTH);
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back('{data: in_data, tag: in_tag});
      end
    end
  end

  task automatic check_port(input string who, input int obs, input logic ov,
                            input logic [WIDTH-1:0] od, input logic ot, input logic om,
                            input logic [2:0] cnt, input logic ir, input logic ovf);
    int  sz;
    bit  exp_mask;
    sz = m_q.size();
    chk({who, ".count"}, int'(cnt), sz);
    chk({who, ".in_ready"}, int'(ir), int'(sz < DEPTH));
    chk({who, ".out_valid"}, int'(ov), int'(sz > 0));
    chk({who, ".overflow"}, int'(ovf), int'(m_ovf));
    if (sz > 0) begin
      exp_mask = (int'(m_q[0].tag) > obs);
      chk({who, ".out_tag"}, int'(ot), int'(m_q[0].tag));
      chk({who, ".out_masked"}, int'(om), int'(exp_mask));
      chk({who, ".out_data"}, int'(od), exp_mask ? 0 : int'(m_q[0].data));
    end else begin
      chk({who, ".out_masked_empty"}, int'(om), 0);
      chk({who, ".out_data_empty"}, int'(od), 0);
    end
  endtask

  // Monitor: samples between edges, against the model state after the last edge.
  always @(negedge clk) begin
    check_port("obsL", 0, out_valid_l, out_data_l, out_tag_l, out_masked_l, count_l,
               in_ready_l, overflow_l);
    check_port("obsH", 1, out_valid_h, out_data_h, out_tag_h, out_masked_h, count_h,
               in_ready_h, overflow_h);
  end

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit t, input bit r,
                       input bit f);
    in_valid  = v;
    in_data   = d;
    in_tag    = t;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] fill_vals [4];
    fill_vals = '{4'h3, 4'h5, 4'h9, 4'hC};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = 1'b0;
    out_ready = 1'b0;
    #3;
    chk("reset.count", int'(count_l), 0);
    chk("reset.in_ready", int'(in_ready_l), 1);
    chk("reset.out_valid", int'(out_valid_l), 0);
    #9 reset = 1'b0;

    // Fill then drain
    for (int i = 0; i < 4; i++) drive(1'b1, fill_vals[i], 1'b0, 1'b0, 1'b0);
    chk("fill.count", int'(count_l), 4);
    chk("fill.in_ready", int'(in_ready_l), 0);
    drain();
    chk("drain.count", int'(count_l), 0);
    chk("drain.out_valid", int'(out_valid_l), 0);

    // Masking at both clearances
    drive(1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
    chk("mask.L.out_valid", int'(out_valid_l), 1);
    chk("mask.L.out_masked", int'(out_masked_l), 1);
    chk("mask.L.out_data", int'(out_data_l), 0);
    chk("mask.L.out_tag", int'(out_tag_l), 1);
    chk("mask.H.out_data", int'(out_data_h), 4'hA);
    chk("mask.H.out_masked", int'(out_masked_h), 0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("mask.pop.count", int'(count_l), 0);

    // Full with simultaneous pop: no push-through, overflow latches
    for (int i = 0; i < 4; i++) drive(1'b1, 4'(i + 1), 1'(i), 1'b0, 1'b0);
    drive(1'b1, 4'hE, 1'b0, 1'b1, 1'b0);
    chk("fullpop.count", int'(count_l), 3);
    chk("fullpop.overflow", int'(overflow_l), 1);
    drive(1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
    chk("fullpop.refill", int'(count_l), 4);
    drain();

    // Wrap-around with steady push+pop
    drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b1, 1'b0);
      chk("wrap.count", int'(count_l), 1);
    end
    drain();

    // Flush beats push/pop and leaves overflow set
    drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'h3, 1'b0, 1'b1, 1'b1);
    chk("flush.count", int'(count_l), 0);
    chk("flush.out_valid", int'(out_valid_l), 0);
    chk("flush.overflow", int'(overflow_l), 1);

    // Asynchronous reset between edges
    drive(1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("areset.count", int'(count_l), 0);
    chk("areset.out_valid", int'(out_valid_l), 0);
    chk("areset.overflow", int'(overflow_l), 0);
    #2 reset = 1'b0;
    @(posedge clk); #2;
    drive(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    chk("areset.first.valid", int'(out_valid_h), 1);
    chk("areset.first.data", int'(out_data_h), 7);
    drain();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 99) < 60), 4'($urandom), 1'($urandom),
            1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 31) == 0));
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
